// File: rtl/torreta_disparo_multi.sv
// Multi-barrel fire-control unit: threat compare, single/burst firing with
// shared prepare/fire/reload timer, round-robin barrel rotation, ammo counter.
module torreta_disparo_multi #(
   parameter int N_CANHOES = 2,
   parameter int M_MUNICAO = 16,
   parameter int N_MUNICAO = 5,
   parameter int T_PREPARA = 100_000,
   parameter int T_DISPARO = 100_000,
   parameter int T_RECARGA = 100_000,
   parameter int N_TEMPO   = 25
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 medida_pronto,
   input  logic [11:0]          medida,
   input  logic [11:0]          limiar,
   input  logic                 habilitar,
   input  logic                 modo_rajada,
   input  logic [1:0]           tamanho_rajada,
   input  logic                 adiciona_municao,
   output logic                 ameaca_detectada,
   output logic                 pronto,
   output logic                 disparando,
   output logic                 fim_disparo,
   output logic [N_CANHOES-1:0] canhao_ativo,
   output logic [N_MUNICAO-1:0] municao,
   output logic                 sem_municao,
   output logic [2:0]           db_estado
);

   typedef enum logic [2:0] {
      INICIAL = 3'd0,
      OCIOSO  = 3'd1,
      PREPARA = 3'd2,
      DISPARA = 3'd3,
      RECARGA = 3'd4
   } estado_t;

   localparam logic [N_TEMPO-1:0]   LIM_PREP = N_TEMPO'(T_PREPARA - 1);
   localparam logic [N_TEMPO-1:0]   LIM_DISP = N_TEMPO'(T_DISPARO - 1);
   localparam logic [N_TEMPO-1:0]   LIM_REC  = N_TEMPO'(T_RECARGA - 1);
   localparam logic [N_MUNICAO-1:0] MUN_MAX  = N_MUNICAO'(M_MUNICAO);

   estado_t              estado, estado_prox;
   logic [N_TEMPO-1:0]   tempo, tempo_prox;
   logic [1:0]           disparos, disparos_prox;
   logic [N_CANHOES-1:0] canhao, canhao_prox;
   logic [N_MUNICAO-1:0] mun, mun_prox;
   logic                 adic_ant, borda;
   logic                 ameaca_r, pronto_r, disp_r, fim_r;

   always_comb begin
      estado_prox   = estado;
      disparos_prox = disparos;
      canhao_prox   = canhao;
      case (estado)
         INICIAL: estado_prox = OCIOSO;
         OCIOSO: begin
            if (habilitar && ameaca_r && (mun != '0)) begin
               estado_prox   = PREPARA;
               disparos_prox = (modo_rajada && (tamanho_rajada != 2'd0)) ? tamanho_rajada : 2'd1;
            end
         end
         PREPARA: begin
            if (!habilitar)
               estado_prox = OCIOSO;
            else if (tempo == LIM_PREP)
               estado_prox = DISPARA;
         end
         DISPARA: begin
            if (tempo == LIM_DISP)
               estado_prox = RECARGA;
         end
         RECARGA: begin
            if (tempo == LIM_REC) begin
               // rotate-left with wrap; degenerates to a hold when there is a single barrel
               canhao_prox   = (canhao << 1) | (canhao >> (N_CANHOES - 1));
               disparos_prox = disparos - 2'd1;
               if ((disparos_prox != 2'd0) && (mun != '0) && habilitar)
                  estado_prox = DISPARA;
               else
                  estado_prox = OCIOSO;
            end
         end
         default: estado_prox = INICIAL;
      endcase

      if ((estado_prox != estado) || (estado_prox == OCIOSO) || (estado_prox == INICIAL))
         tempo_prox = '0;
      else
         tempo_prox = tempo + 1'b1;

      // an added round and a spent round in the same cycle cancel out
      borda    = adiciona_municao && !adic_ant;
      mun_prox = mun;
      if (borda && !fim_r) begin
         if (mun != MUN_MAX)
            mun_prox = mun + 1'b1;
      end else if (fim_r && !borda) begin
         if (mun != '0)
            mun_prox = mun - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado   <= INICIAL;
         tempo    <= '0;
         disparos <= '0;
         canhao   <= N_CANHOES'(1);
         mun      <= '0;
         adic_ant <= 1'b0;
         ameaca_r <= 1'b0;
         pronto_r <= 1'b0;
         disp_r   <= 1'b0;
         fim_r    <= 1'b0;
      end else begin
         estado   <= estado_prox;
         tempo    <= tempo_prox;
         disparos <= disparos_prox;
         canhao   <= canhao_prox;
         mun      <= mun_prox;
         adic_ant <= adiciona_municao;
         if (medida_pronto)
            ameaca_r <= (medida < limiar);
         pronto_r <= (estado_prox == OCIOSO);
         disp_r   <= (estado_prox == DISPARA);
         fim_r    <= (estado_prox == DISPARA) && (tempo_prox == LIM_DISP);
      end
   end

   assign ameaca_detectada = ameaca_r;
   assign pronto           = pronto_r;
   assign disparando       = disp_r;
   assign fim_disparo      = fim_r;
   assign canhao_ativo     = canhao;
   assign municao          = mun;
   assign sem_municao      = (mun == '0);
   assign db_estado        = estado;

endmodule
